// File: rtl/prog_loader.sv
// Boot-time program loader: frames a 16-bit din stream into 32-bit instruction
// writes, verifies an XOR checksum and holds the core in reset until it passes.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [15:0]       din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [15:0]   DEPTH16 = 16'(DEPTH);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_HDR, S_HI, S_LO, S_CSUM, S_RUN, S_ERR
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   cnt;   // one bit wider than the address so N = DEPTH fits
  logic [ADDR_W:0]   idx;
  logic [15:0]       csum;
  logic [15:0]       hi;
  logic              acc;

  assign acc = din_valid & din_ready;

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= S_HDR;
      din_ready  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      csum       <= '0;
      hi         <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_HDR: begin
          din_ready <= 1'b1;
          if (acc) begin
            if (din == '0 || din > DEPTH16) begin
              state     <= S_ERR;
              din_ready <= 1'b0;
              err       <= 1'b1;
            end else begin
              cnt   <= din[ADDR_W:0];
              idx   <= '0;
              csum  <= din;
              state <= S_HI;
            end
          end
        end
        S_HI: begin
          if (acc) begin
            hi    <= din;
            csum  <= csum ^ din;
            state <= S_LO;
          end
        end
        S_LO: begin
          if (acc) begin
            csum       <= csum ^ din;
            imem_wdata <= INST_W'({hi, din});
            imem_we    <= 1'b1;
            imem_addr  <= idx[ADDR_W-1:0];
            if (idx == cnt - ONE) begin
              state <= S_CSUM;
            end else begin
              idx   <= idx + ONE;
              state <= S_HI;
            end
          end
        end
        S_CSUM: begin
          if (acc) begin
            din_ready <= 1'b0;
            if (din == csum) begin
              state     <= S_RUN;
              cpu_rst   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        S_RUN, S_ERR: begin
          // memory contents are kept; only the handshake and status restart
          if (reload) begin
            state     <= S_HDR;
            din_ready <= 1'b1;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            err       <= 1'b0;
          end
        end
        default: begin
          state     <= S_HDR;
          din_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against an image-level model.
module tb_prog_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic [15:0]   din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          reload = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          err;

  prog_loader #(.ADDR_W(AW), .INST_W(32)) dut (
    .clk(clk), .sys_rst(sys_rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
    .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;
  logic [35:0] wq[$];
  logic [31:0] prog [0:15];

  // observe writes and accepted words mid-cycle, after the bench has driven
  always @(negedge clk) begin
    #1;
    if (imem_we) wq.push_back({imem_addr, imem_wdata});
    if (din_valid && din_ready && sys_rst) acc_cnt++;
  end

  function automatic logic [15:0] img_csum(input int n);
    logic [15:0] x;
    x = 16'(n);
    for (int i = 0; i < n; i++) x = x ^ prog[i][31:16] ^ prog[i][15:0];
    return x;
  endfunction

  // index of first write that disagrees with the image, -1 if all agree
  function automatic int first_bad_write(input int n);
    if (wq.size() != n) return -2;
    for (int i = 0; i < n; i++)
      if (wq[i] !== {4'(i), prog[i]}) return i;
    return -1;
  endfunction

  task automatic send(input logic [15:0] w, input bit stall);
    int t;
    if (stall)
      while ($urandom_range(0, 2) == 0) begin
        din_valid = 1'b0;
        din = 16'($urandom);
        @(negedge clk);
      end
    din = w;
    din_valid = 1'b1;
    t = 0;
    while (!din_ready && t < 200) begin @(negedge clk); t++; end
    if (!din_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout word=%h din_ready stayed 0", w);
    end else @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic load(input int n, input bit stall, input logic [15:0] flip);
    send(16'(n), stall);
    for (int i = 0; i < n; i++) begin
      send(prog[i][31:16], stall);
      send(prog[i][15:0], stall);
    end
    send(img_csum(n) ^ flip, stall);
  endtask

  task automatic pulse_reload;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic set_nominal;
    prog[0] = 32'h0841_0005;
    prog[1] = 32'hD800_0000;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({din_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, err} !== {1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b", din_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, err);
    end
    sys_rst = 1'b1;
    #1;
    n_vec++;
    if (din_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge got %b want 0", din_ready); end
    @(negedge clk);
    n_vec++;
    if (din_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge got %b want 1", din_ready); end
  endtask

  task automatic test_nominal;
    wq.delete(); acc_cnt = 0;
    set_nominal();
    send(16'h0002, 0); send(16'h0841, 0); send(16'h0005, 0);
    send(16'hD800, 0); send(16'h0000, 0); send(16'hD046, 0);
    n_vec++;
    if (wq.size() != 2 || wq[0] !== {4'h0, 32'h0841_0005} || wq[1] !== {4'h1, 32'hD800_0000}) begin
      n_err++; $display("FAIL nominal_writes got %0d writes want 2 (0:08410005 1:D8000000)", wq.size());
    end
    n_vec++;
    if ({load_done, cpu_rst, err} !== 3'b100) begin
      n_err++; $display("FAIL nominal_status got done/crst/err=%b want 100", {load_done, cpu_rst, err});
    end
    n_vec++;
    if (acc_cnt != 6) begin n_err++; $display("FAIL nominal_accepts got %0d want 6", acc_cnt); end
  endtask

  task automatic test_bad_csum;
    pulse_reload();
    wq.delete();
    set_nominal();
    load(2, 0, 16'h0001);
    n_vec++;
    if (first_bad_write(2) != -1) begin n_err++; $display("FAIL badcsum_writes code=%0d want -1", first_bad_write(2)); end
    n_vec++;
    if ({load_done, cpu_rst, err} !== 3'b011) begin
      n_err++; $display("FAIL badcsum_status got done/crst/err=%b want 011", {load_done, cpu_rst, err});
    end
  endtask

  task automatic test_framing;
    pulse_reload();
    wq.delete();
    send(16'h0000, 0);
    n_vec++;
    if ({err, cpu_rst, din_ready} !== 3'b110) begin
      n_err++; $display("FAIL hdr_zero got err/crst/rdy=%b want 110", {err, cpu_rst, din_ready});
    end
    pulse_reload();
    send(16'h0011, 0);
    repeat (3) @(negedge clk);
    n_vec++;
    if (err !== 1'b1 || wq.size() != 0) begin
      n_err++; $display("FAIL hdr_oversize got err=%b writes=%0d want err=1 writes=0", err, wq.size());
    end
    pulse_reload();
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    wq.delete(); acc_cnt = 0;
    load(16, 0, 16'h0000);
    n_vec++;
    if (first_bad_write(16) != -1) begin n_err++; $display("FAIL full_writes code=%0d want -1", first_bad_write(16)); end
    n_vec++;
    if ({load_done, cpu_rst, err, acc_cnt} !== {3'b100, 32'd34}) begin
      n_err++; $display("FAIL full_status got done/crst/err=%b acc=%0d want 100 acc=34", {load_done, cpu_rst, err}, acc_cnt);
    end
  endtask

  task automatic test_stalls;
    int n;
    for (int it = 0; it < 6; it++) begin
      pulse_reload();
      n = (it == 0) ? 2 : int'($urandom_range(1, 16));
      if (it == 0) set_nominal();
      else for (int i = 0; i < n; i++) prog[i] = $urandom;
      wq.delete(); acc_cnt = 0;
      load(n, 1, 16'h0000);
      n_vec++;
      if (first_bad_write(n) != -1) begin
        n_err++; $display("FAIL stall_writes it=%0d n=%0d code=%0d want -1", it, n, first_bad_write(n));
      end
      n_vec++;
      if ({load_done, cpu_rst, err} !== 3'b100 || acc_cnt != 2*n+2) begin
        n_err++; $display("FAIL stall_status it=%0d done/crst/err=%b acc=%0d want 100 acc=%0d", it, {load_done, cpu_rst, err}, acc_cnt, 2*n+2);
      end
    end
  endtask

  task automatic test_reload;
    pulse_reload();
    n_vec++;
    if ({cpu_rst, load_done, err, din_ready} !== 4'b1001) begin
      n_err++; $display("FAIL reload_status got crst/done/err/rdy=%b want 1001", {cpu_rst, load_done, err, din_ready});
    end
    wq.delete();
    send(16'h0001, 0); send(16'h1234, 0); send(16'h5678, 0); send(16'h444D, 0);
    n_vec++;
    if (wq.size() != 1 || wq[0] !== {4'h0, 32'h1234_5678} || load_done !== 1'b1 || cpu_rst !== 1'b0) begin
      n_err++; $display("FAIL reload_single writes=%0d done=%b crst=%b want 1 write 0:12345678 done=1 crst=0", wq.size(), load_done, cpu_rst);
    end
    // reload during HI must be ignored
    pulse_reload();
    set_nominal();
    wq.delete();
    send(16'h0002, 0);
    pulse_reload();
    send(prog[0][31:16], 0); send(prog[0][15:0], 0);
    send(prog[1][31:16], 0); send(prog[1][15:0], 0);
    send(img_csum(2), 0);
    n_vec++;
    if (first_bad_write(2) != -1 || {load_done, cpu_rst, err} !== 3'b100) begin
      n_err++; $display("FAIL reload_in_hi code=%0d done/crst/err=%b want -1 100", first_bad_write(2), {load_done, cpu_rst, err});
    end
  endtask

  task automatic test_reset_midload;
    pulse_reload();
    set_nominal();
    wq.delete();
    send(16'h0002, 0);
    send(16'h0841, 0);
    din = 16'h0005; din_valid = 1'b1;
    sys_rst = 1'b0;
    #1;
    n_vec++;
    if ({din_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, err} !== {1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL midload_reset got rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b", din_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, err);
    end
    repeat (3) @(negedge clk);
    din_valid = 1'b0;
    sys_rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (wq.size() != 0) begin n_err++; $display("FAIL midload_nowrite got %0d writes want 0", wq.size()); end
    load(2, 0, 16'h0000);
    n_vec++;
    if (first_bad_write(2) != -1 || {load_done, cpu_rst, err} !== 3'b100) begin
      n_err++; $display("FAIL after_reset_load code=%0d done/crst/err=%b want -1 100", first_bad_write(2), {load_done, cpu_rst, err});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_bad_csum();
    test_framing();
    test_stalls();
    test_reload();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits between the external `din` input stream and the processor's instruction memory. Accepts a framed program image (header word count, instruction halves, checksum) over a 16-bit valid/ready handshake, assembles 32-bit instruction words, writes them into instruction memory, and holds the processor core in reset until a complete, checksum-verified image is stored. It supplies the processor's program image through `din` at run time rather than from a simulation file.

## Interface
- `ADDR_W`, 4: instruction memory address width; capacity `DEPTH` = 2^ADDR_W words.
- `INST_W`, 32: instruction width; fixed at two 16-bit halves.

- `clk`  in  1  system clock; all logic on the rising edge.
- `sys_rst`  in  1  asynchronous, active-low reset.
- `din`  in  16  loader stream data.
- `din_valid`  in  1  `din` holds a valid word.
- `din_ready`  out  1  loader can accept a word this cycle.
- `reload`  in  1  single-cycle request to restart loading; honoured in RUN and ERR only.
- `imem_we`  out  1  instruction memory write strobe, one cycle per instruction.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  INST_W  write data, `{hi, lo}`.
- `cpu_rst`  out  1  active-high reset to the processor core.
- `load_done`  out  1  image stored and verified.
- `err`  out  1  framing or checksum failure.

## Operation
- A word is accepted when `din_valid & din_ready` are both high on a rising edge. `din_ready` = 1 only in HDR, HI, LO and CSUM.
- States:
  - HDR: accept the count N. If N = 0 or N > DEPTH → ERR. Otherwise latch N, clear the address, set `csum` = N → HI.
  - HI: accept the upper half into a holding register, `csum ^= din` → LO.
  - LO: accept the lower half, `csum ^= din`. Register `imem_wdata = {hi, din}`, `imem_we = 1`, `imem_addr` = current index. If index = N-1 → CSUM, else increment index → HI.
  - CSUM: accept one word. If it equals `csum` → RUN, else → ERR.
  - RUN: `cpu_rst` = 0, `load_done` = 1. `reload` → HDR.
  - ERR: `err` = 1, `cpu_rst` = 1. `reload` → HDR.
- On `reload`, the next cycle reasserts `cpu_rst` and clears `load_done` and `err`. Memory contents are not cleared.
- `reload` is ignored in HDR, HI, LO and CSUM.
- The index is ADDR_W+1 bits wide internally, so N = DEPTH is legal. The address never wraps within a load.
- The checksum is a 16-bit XOR over the header and all instruction halves, excluding the checksum word itself.

## Timing
- Reset values: `din_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `cpu_rst` 1, `load_done` 0, `err` 0. State returns to HDR.
- `din_ready` rises on the first clock edge after `sys_rst` deasserts.
- `imem_we` is registered and pulses for exactly one cycle, in the cycle after the LO accept. `imem_addr` and `imem_wdata` are valid in the same cycle.
- With `din_valid` held high, the loader accepts one word per cycle. A load of N instructions takes 2N+2 accepted words.
- `cpu_rst` falls and `load_done` rises in the cycle after the CSUM accept. The final `imem_we` has completed before that cycle.
- `din_valid` low stalls the current state indefinitely with no side effects.
- Words presented while `din_ready` = 0 are dropped. The source must hold them until `din_ready` = 1.
- If `sys_rst` asserts mid-load, the partial image is abandoned and all outputs take their reset values immediately. Any further `imem_we` is suppressed.

## Test plan
- Nominal load: stream 0x0002, 0x0841, 0x0005, 0xD800, 0x0000, 0xD046 → `imem_we` at addr 0 with 0x08410005, then at addr 1 with 0xD8000000. `load_done` = 1, `cpu_rst` = 0, `err` = 0.
- Bad checksum: same stream with final word 0xD047 → both writes occur, then `err` = 1, `cpu_rst` stays 1, `load_done` = 0.
- Framing: header 0x0000 → ERR. Header 0x0011 with ADDR_W = 4 → ERR, no `imem_we`. Full header 0x0010 with correct checksum → 16 writes at addrs 0..15, then RUN.
- Stalls: toggle `din_valid` randomly during the nominal load → identical writes and final state. No acceptance while `din_valid` = 0.
- Reload: after RUN, pulse `reload`, then load a single instruction (0x0001, 0x1234, 0x5678, 0x444D) → `cpu_rst` = 1 during reload, addr 0 receives 0x12345678, then RUN. A `reload` pulse issued during HI has no effect.
- Reset mid-load: drop `sys_rst` after the first HI accept → all outputs at reset values and no write. A fresh nominal load after release succeeds.
